// File: rtl/hazard_pkg.sv
// Shared encodings and shadow-entry types for the hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned FWD_W_SEL_W = 3;

    localparam logic [FWD_W_SEL_W-1:0] FWD_RF    = 3'd0;
    localparam logic [FWD_W_SEL_W-1:0] FWD_E_ALU = 3'd1;
    localparam logic [FWD_W_SEL_W-1:0] FWD_M_MEM = 3'd2;
    localparam logic [FWD_W_SEL_W-1:0] FWD_M_ALU = 3'd3;
    localparam logic [FWD_W_SEL_W-1:0] FWD_W     = 3'd4;

    localparam int unsigned SH_FLAGS_W = 3;

    // Destination tag is kept beside this struct because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem2reg;
    } sh_flags_t;

endpackage

// File: rtl/hazard_track.sv
// E/M/W shadow pipeline of in-flight destination tags; bubble loads an invalid E entry.
module hazard_track
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  sh_flags_t         d_flags,
    input  logic [REG_AW-1:0] d_dst,
    output sh_flags_t         e_flags,
    output sh_flags_t         m_flags,
    output sh_flags_t         w_flags,
    output logic [REG_AW-1:0] e_dst,
    output logic [REG_AW-1:0] m_dst,
    output logic [REG_AW-1:0] w_dst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_flags <= '0;
            m_flags <= '0;
            w_flags <= '0;
            e_dst   <= '0;
            m_dst   <= '0;
            w_dst   <= '0;
        end else begin
            w_flags <= m_flags;
            w_dst   <= m_dst;
            m_flags <= e_flags;
            m_dst   <= e_dst;
            if (bubble) begin
                e_flags <= '0;
                e_dst   <= '0;
            end else begin
                e_flags <= d_flags;
                e_dst   <= d_dst;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline with branches resolved in D.
// Optional HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned W_FWD   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           d_valid,
    input  logic [NUM_SRC*REG_AW-1:0]      d_src,
    input  logic [NUM_SRC-1:0]             d_src_used,
    input  logic [REG_AW-1:0]              d_dst,
    input  logic                           d_reg_write,
    input  logic                           d_mem2reg,
    input  logic                           d_branch,
    input  logic                           d_taken,
    input  logic                           d_mdu_start,
    input  logic                           d_mdu_use,
    output logic                           stall_f,
    output logic                           stall_d,
    output logic                           flush_d,
    output logic                           bubble_e,
    output logic [NUM_SRC*FWD_W_SEL_W-1:0] fwd_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cnt,
    output logic [31:0]                    perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MDU_LAT + 1);

    sh_flags_t         d_flags, e_flags, m_flags, w_flags;
    logic [REG_AW-1:0] e_dst, m_dst, w_dst;
    logic [CNT_W-1:0]  mdu_cnt;

    logic [REG_AW-1:0] src;
    logic              live, hit_e, hit_m, hit_w;
    logic              load_use, br_hz, mdu_hz, stall, flush, bubble;
    logic [NUM_SRC*FWD_W_SEL_W-1:0] sel;

    assign d_flags = '{valid: d_valid, reg_write: d_reg_write, mem2reg: d_mem2reg};

    hazard_track #(
        .REG_AW(REG_AW)
    ) u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (bubble),
        .d_flags (d_flags),
        .d_dst   (d_dst),
        .e_flags (e_flags),
        .m_flags (m_flags),
        .w_flags (w_flags),
        .e_dst   (e_dst),
        .m_dst   (m_dst),
        .w_dst   (w_dst)
    );

    always_comb begin
        src      = '0;
        live     = 1'b0;
        hit_e    = 1'b0;
        hit_m    = 1'b0;
        hit_w    = 1'b0;
        load_use = 1'b0;
        br_hz    = 1'b0;
        sel      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src   = d_src[i*REG_AW +: REG_AW];
            live  = d_src_used[i] && (src != '0);
            hit_e = live && e_flags.valid && e_flags.reg_write && (e_dst == src);
            hit_m = live && m_flags.valid && m_flags.reg_write && (m_dst == src);
            hit_w = live && w_flags.valid && w_flags.reg_write && (w_dst == src);
            if (hit_e)
                sel[i*FWD_W_SEL_W +: FWD_W_SEL_W] = FWD_E_ALU;
            else if (hit_m)
                sel[i*FWD_W_SEL_W +: FWD_W_SEL_W] = m_flags.mem2reg ? FWD_M_MEM : FWD_M_ALU;
            else if (hit_w && (W_FWD != 0))
                sel[i*FWD_W_SEL_W +: FWD_W_SEL_W] = FWD_W;
            else
                sel[i*FWD_W_SEL_W +: FWD_W_SEL_W] = FWD_RF;
            load_use = load_use || (hit_e && e_flags.mem2reg);
            br_hz    = br_hz || hit_e || (hit_m && m_flags.mem2reg);
        end
    end

    assign mdu_hz = (mdu_cnt != '0) && (d_mdu_use || d_mdu_start);
    assign stall  = d_valid && (load_use || (d_branch && br_hz) || mdu_hz);
    // rst_n gate keeps flush low during reset even though it is built from raw D inputs.
    assign flush  = rst_n && d_valid && d_branch && d_taken && !stall;
    assign bubble = stall || flush || !d_valid;

    assign stall_f  = stall;
    assign stall_d  = stall;
    assign bubble_e = stall;
    assign flush_d  = flush;
    assign fwd_sel  = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_cnt <= '0;
        else if (d_valid && d_mdu_start && !stall)
            mdu_cnt <= CNT_W'(MDU_LAT);
        else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - CNT_W'(1);
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against an age-list model.
module tb_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned NS  = 2;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          d_valid;
    logic [NS*AW-1:0] d_src;
    logic [NS-1:0] d_src_used;
    logic [AW-1:0] d_dst;
    logic          d_reg_write, d_mem2reg, d_branch, d_taken, d_mdu_start, d_mdu_use;
    logic          stall_f, stall_d, flush_d, bubble_e;
    logic [NS*3-1:0] fwd_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_flush_cnt = 0;

    logic [9:0] obs;
    assign obs = {stall_f, stall_d, bubble_e, flush_d, fwd_sel};

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW (AW),
        .NUM_SRC(NS),
        .MDU_LAT(LAT),
        .W_FWD  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_src      (d_src),
        .d_src_used (d_src_used),
        .d_dst      (d_dst),
        .d_reg_write(d_reg_write),
        .d_mem2reg  (d_mem2reg),
        .d_branch   (d_branch),
        .d_taken    (d_taken),
        .d_mdu_start(d_mdu_start),
        .d_mdu_use  (d_mdu_use),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .bubble_e   (bubble_e),
        .fwd_sel    (fwd_sel)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Expected observation vector: {stall_f, stall_d, bubble_e, flush_d, sel1, sel0}
    function automatic logic [9:0] ex(input logic st, input logic fl,
                                      input logic [2:0] f1, input logic [2:0] f0);
        return {st, st, st, fl, f1, f0};
    endfunction

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic rw,
                         input logic m2r, input logic br, input logic tk,
                         input logic ms, input logic mu);
        d_valid = v; d_src = {s1, s0}; d_src_used = used; d_dst = dst;
        d_reg_write = rw; d_mem2reg = m2r; d_branch = br; d_taken = tk;
        d_mdu_start = ms; d_mdu_use = mu;
    endtask

    task automatic nop();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        nop();
        repeat (n) adv();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 3, 4, 2'b11, 3, 1, 0, 1, 1, 1, 1);
        #2;
        total++;
        if (obs !== 10'd0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'd0);
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif
        smp();
        nop();
        rst_n = 1'b1;
        adv();
    endtask

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       m2r;
    } rec_t;

    function automatic bit hit(input rec_t r, input logic [4:0] s, input logic u);
        return u && (s != 0) && r.v && r.rw && (r.dst == s);
    endfunction

    // Model: age[0] is the instruction one ahead of D, age[1] two ahead, age[2] three ahead.
    task automatic test_random(input int n);
        rec_t age[3];
        int   busy;
        logic v, rw, m2r, br, tk, ms, mu, st, fl, lu, bh;
        logic [4:0] s[2];
        logic [4:0] dst;
        logic [1:0] used;
        logic [2:0] sel[2];
        for (int k = 0; k < 3; k++) age[k] = '0;
        busy = 0;
        idle(6);
        for (int c = 0; c < n; c++) begin
            v    = ($urandom_range(0, 9) != 0);
            s[0] = 5'($urandom_range(0, 3));
            s[1] = 5'($urandom_range(0, 3));
            used = 2'($urandom);
            dst  = 5'($urandom_range(0, 3));
            rw   = ($urandom_range(0, 3) != 0);
            m2r  = rw && ($urandom_range(0, 2) == 0);
            br   = ($urandom_range(0, 4) == 0);
            tk   = 1'($urandom);
            ms   = ($urandom_range(0, 7) == 0);
            mu   = ($urandom_range(0, 5) == 0);
            drive(v, s[0], s[1], used, dst, rw, m2r, br, tk, ms, mu);
            lu = 0; bh = 0;
            for (int j = 0; j < 2; j++) begin
                sel[j] = 3'd0;
                if (hit(age[2], s[j], used[j])) sel[j] = 3'd4;
                if (hit(age[1], s[j], used[j])) sel[j] = age[1].m2r ? 3'd2 : 3'd3;
                if (hit(age[0], s[j], used[j])) sel[j] = 3'd1;
                if (hit(age[0], s[j], used[j]) && age[0].m2r) lu = 1;
                if (hit(age[0], s[j], used[j]) || (hit(age[1], s[j], used[j]) && age[1].m2r)) bh = 1;
            end
            st = v && (lu || (br && bh) || (busy > 0 && (mu || ms)));
            fl = v && br && tk && !st;
            smp();
            total++;
            if (obs !== ex(st, fl, sel[1], sel[0])) begin
                bad++;
                $display("FAIL random_cycle%0d got=%b exp=%b", c, obs, ex(st, fl, sel[1], sel[0]));
            end
            if (st) m_stall_cnt++;
            if (fl) m_flush_cnt++;
            age[2] = age[1];
            age[1] = age[0];
            age[0] = (v && !st && !fl) ? rec_t'{1'b1, dst, rw, m2r} : rec_t'('0);
            if (v && ms && !st) busy = LAT;
            else if (busy > 0) busy--;
            adv();
        end
        nop();
`ifdef HAZARD_PERF_EN
        total++;
        if (perf_stall_cnt !== m_stall_cnt || perf_flush_cnt !== m_flush_cnt) begin
            bad++;
            $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d",
                     perf_stall_cnt, perf_flush_cnt, m_stall_cnt, m_flush_cnt);
        end
`endif
    endtask

    task automatic test_alu_fwd();
        idle(6);
        drive(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 0, 0)) begin bad++; $display("FAIL alu_first got=%b exp=%b", obs, ex(0, 0, 0, 0)); end
        adv();
        drive(1, 3, 0, 2'b01, 7, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 0, 1)) begin bad++; $display("FAIL alu_e_fwd got=%b exp=%b", obs, ex(0, 0, 0, 1)); end
        adv();
        drive(1, 7, 3, 2'b11, 8, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 3, 1)) begin bad++; $display("FAIL alu_m_fwd got=%b exp=%b", obs, ex(0, 0, 3, 1)); end
        adv();
        drive(1, 3, 8, 2'b11, 9, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 1, 4)) begin bad++; $display("FAIL w_fwd got=%b exp=%b", obs, ex(0, 0, 1, 4)); end
        adv();
    endtask

    task automatic test_load_use();
        idle(6);
        drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0);
        adv();
        drive(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(1, 0, 0, 1)) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", obs, ex(1, 0, 0, 1)); end
        adv();
        smp(); total++;
        if (obs !== ex(0, 0, 0, 2)) begin bad++; $display("FAIL load_use_fwd got=%b exp=%b", obs, ex(0, 0, 0, 2)); end
        adv();
    endtask

    task automatic test_branch();
        idle(6);
        drive(1, 1, 2, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 1, 0, 0)) begin bad++; $display("FAIL br_flush got=%b exp=%b", obs, ex(0, 1, 0, 0)); end
        adv();
        drive(1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 0, 0)) begin bad++; $display("FAIL br_flush_once got=%b exp=%b", obs, ex(0, 0, 0, 0)); end
        adv();
        drive(1, 4, 2, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        smp(); total++;
        if (obs !== ex(1, 0, 0, 1)) begin bad++; $display("FAIL br_opnd_stall got=%b exp=%b", obs, ex(1, 0, 0, 1)); end
        adv();
        smp(); total++;
        if (obs !== ex(0, 1, 0, 3)) begin bad++; $display("FAIL br_resolve got=%b exp=%b", obs, ex(0, 1, 0, 3)); end
        adv();
    endtask

    task automatic test_r0();
        idle(6);
        drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0);
        adv();
        drive(1, 0, 0, 2'b11, 2, 1, 0, 0, 0, 0, 0);
        smp(); total++;
        if (obs !== ex(0, 0, 0, 0)) begin bad++; $display("FAIL r0_no_fwd got=%b exp=%b", obs, ex(0, 0, 0, 0)); end
        adv();
        drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0);
        adv();
        drive(0, 5, 5, 2'b11, 0, 0, 0, 1, 1, 0, 0);
        smp(); total++;
        if (obs[9:6] !== 4'b0000) begin bad++; $display("FAIL dvalid_suppress got=%b exp=%b", obs[9:6], 4'b0000); end
        adv();
    endtask

    task automatic test_mdu();
        int n;
        idle(6);
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        smp(); total++;
        if (obs !== 10'd0) begin bad++; $display("FAIL mdu_start got=%b exp=%b", obs, 10'd0); end
        adv();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (!stall_d) break;
            n++;
            adv();
        end
        total++;
        if (n != LAT) begin bad++; $display("FAIL mdu_use_stall got=%0d exp=%0d", n, LAT); end
        adv();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        smp(); total++;
        if (obs !== 10'd0) begin bad++; $display("FAIL mdu_restart got=%b exp=%b", obs, 10'd0); end
        adv();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (!stall_d) break;
            n++;
            adv();
        end
        total++;
        if (n != LAT) begin bad++; $display("FAIL mdu_busy_start got=%0d exp=%0d", n, LAT); end
        adv();
        idle(6);
    endtask

    task automatic test_reset_mid();
        idle(6);
        drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0);
        adv();
        drive(1, 5, 1, 2'b11, 6, 1, 0, 1, 1, 0, 0);
        smp(); total++;
        if (obs !== ex(1, 0, 0, 1)) begin bad++; $display("FAIL pre_rst_stall got=%b exp=%b", obs, ex(1, 0, 0, 1)); end
        #1 rst_n = 1'b0;
        #1; total++;
        if (obs !== 10'd0) begin bad++; $display("FAIL async_rst got=%b exp=%b", obs, 10'd0); end
        drive(1, 5, 5, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        smp();
        rst_n = 1'b1;
        #1; total++;
        if (obs !== 10'd0) begin bad++; $display("FAIL stale_tag got=%b exp=%b", obs, 10'd0); end
`ifdef HAZARD_PERF_EN
        total++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif
        adv();
        nop();
    endtask

    initial begin
        test_reset();
        test_random(400);
        test_alu_fwd();
        test_load_use();
        test_branch();
        test_r0();
        test_mdu();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
